ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter, the transmit counterpart of the PS/2 receive path. It accepts one command byte per valid/ready handshake and performs the host request-to-send sequence: clock inhibit, start bit, 8 data bits LSB-first, odd parity, stop, then device ack. It drives the open-drain PS/2 clock and data lines through output enables; top-level pads implement the drive-low/release behaviour. It reports completion or failure per byte and raises a busy flag so the receiver can ignore line activity during transmission.

## Interface
- INHIBIT_CYCLES, 5000: app_clk cycles the host holds PS/2 clock low before the start bit; 100 us at 50 MHz.
- TIMEOUT_CYCLES, 750000: cycles from clock release to transaction end before abort; 15 ms at 50 MHz.
- app_clk  in  1  system clock; the only clock.
- app_arst_n  in  1  asynchronous, active-low reset.
- ps2_clk_in  in  1  PS/2 clock pad input, asynchronous.
- ps2_data_in  in  1  PS/2 data pad input, asynchronous.
- ps2_clk_oe  out  1  1 = drive PS/2 clock low; 0 = release.
- ps2_data_oe  out  1  1 = drive PS/2 data low; 0 = release.
- tx_valid  in  1  command byte present.
- tx_data  in  8  command byte.
- tx_ready  out  1  block idle and able to accept a byte.
- tx_busy  out  1  transaction in progress; receive path gates on this.
- tx_done  out  1  one-cycle pulse at transaction end.
- tx_err  out  1  valid with tx_done: 1 = no ack or timeout.

## Operation
- Inputs pass through a 2-flop synchronizer with reset value 1. Falling edge = previous synced clock 1 and current synced clock 0.
- Byte accepted when tx_valid && tx_ready. On acceptance, load 11-bit shift register {1'b1 stop, ~^tx_data parity, tx_data, 1'b0 start}. Load bit count 0.
- IDLE: both oe 0; tx_ready 1; tx_busy 0. On accept, go to INHIBIT.
- INHIBIT: clk_oe 1; data_oe 0. Count INHIBIT_CYCLES cycles, then go to REQ.
- REQ: one cycle with clk_oe 1 and data_oe 1. Then go to SEND. Timeout counter clears here.
- SEND: clk_oe 0; data_oe = ~shift[0]. Each falling edge shifts right and increments the count. After the 10th falling edge, shift[0] is stop and data is released; go to ACK.
- ACK: on the next falling edge, latch ack_ok = ~synced data; go to WAIT_IDLE.
- WAIT_IDLE: when synced clock and synced data are both 1, go to DONE.
- DONE: tx_done 1; tx_err = ~ack_ok; return to IDLE.
- Timeout: in SEND, ACK or WAIT_IDLE, when the counter reaches TIMEOUT_CYCLES-1, release both lines and go to DONE with tx_err 1.
- tx_valid is ignored while tx_ready is 0. tx_data is not sampled after acceptance.
- tx_busy = state != IDLE.

## Timing
- Reset values: ps2_clk_oe 0, ps2_data_oe 0, tx_ready 1, tx_busy 0, tx_done 0, tx_err 0. Reset is asynchronous; a reset mid-transaction releases both lines immediately.
- Accept cycle N: clk_oe is 1 from N+1 through N+INHIBIT_CYCLES. REQ occupies N+INHIBIT_CYCLES+1. Clock is released at N+INHIBIT_CYCLES+2.
- Edge latency: a pad falling edge is recognized 3 cycles later. Data updates on the next cycle, well inside the device low phase of at least 30 us.
- tx_done pulses exactly once per accepted byte. tx_ready rises the cycle after tx_done. Earliest next accept is that cycle.
- tx_err holds its value until the next tx_done.
- A falling edge and the timeout terminal count in the same cycle: the timeout wins.
- Any falling edge in INHIBIT or REQ is ignored.

## Structure
- ps2_pkg holds the state enum (IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE, DONE), frame length 11, and default cycle constants.
- Sub-module ps2_sync_edge: 2-flop synchronizer plus falling-edge detect for clock and synchronized data. It is shared with the receiver.
- The counter sizes are $clog2 of the larger of INHIBIT_CYCLES and TIMEOUT_CYCLES. One counter is reused for both inhibit and timeout.

## Test plan
- Send tx_data 0xF4 with a device model that acks -> sampled bits 0,0,0,1,0,1,1,1,1, parity 0, stop 1; tx_done with tx_err 0.
- Send 0xED, then 0x00 back-to-back -> parity 1 both times. Second accept happens the cycle after the first tx_done. clk_oe low for exactly INHIBIT_CYCLES+1 cycles each time.
- Device model holds data high during the ack slot -> tx_done with tx_err 1; lines released.
- Device model never clocks after REQ, with TIMEOUT_CYCLES set to 1000 -> tx_done and tx_err 1 exactly 1000 cycles after clock release; both oe 0.
- Assert app_arst_n low midway through SEND -> oe outputs, tx_busy and tx_done go to 0 without waiting for an app_clk edge; tx_ready is 1; no tx_done after reset.
- Hold tx_valid high with changing tx_data while busy -> only the byte accepted at the handshake is transmitted; no second accept until tx_ready is 1.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, state encoding and frame builder for the PS/2 host transmitter
package ps2_pkg;

   localparam int FRAME_LEN          = 11;
   localparam int INHIBIT_CYCLES_DEF = 5000;
   localparam int TIMEOUT_CYCLES_DEF = 750000;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_INHIBIT   = 3'd1;
   localparam state_t ST_REQ       = 3'd2;
   localparam state_t ST_SEND      = 3'd3;
   localparam state_t ST_ACK       = 3'd4;
   localparam state_t ST_WAIT_IDLE = 3'd5;
   localparam state_t ST_DONE      = 3'd6;

   // Bit 0 goes on the wire first: start, data LSB-first, odd parity, stop.
   function automatic logic [FRAME_LEN-1:0] build_frame(input logic [7:0] data);
      return {1'b1, ~^data, data, 1'b0};
   endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command handshake and open-drain pad bundle for the PS/2 host transmitter
interface ps2_host_tx_if;

   logic       ps2_clk_in;
   logic       ps2_data_in;
   logic       ps2_clk_oe;
   logic       ps2_data_oe;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_err;

   modport master (
      output ps2_clk_in, ps2_data_in, tx_valid, tx_data,
      input  ps2_clk_oe, ps2_data_oe, tx_ready, tx_busy, tx_done, tx_err
   );

   modport slave (
      input  ps2_clk_in, ps2_data_in, tx_valid, tx_data,
      output ps2_clk_oe, ps2_data_oe, tx_ready, tx_busy, tx_done, tx_err
   );

endinterface

// File: rtl/ps2_sync_edge.sv
// rtl/ps2_sync_edge.sv - two-flop pad synchronizer with PS/2 clock falling-edge detect
module ps2_sync_edge (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic ps2_clk_i,
   input  logic ps2_data_i,
   output logic clk_sync_o,
   output logic data_sync_o,
   output logic clk_fall_o
);

   logic [1:0] clk_sync_q;
   logic [1:0] clk_sync_d;
   logic [1:0] data_sync_q;
   logic [1:0] data_sync_d;
   logic       clk_prev_q;
   logic       clk_prev_d;

   assign clk_sync_d  = {clk_sync_q[0], ps2_clk_i};
   assign data_sync_d = {data_sync_q[0], ps2_data_i};
   assign clk_prev_d  = clk_sync_q[1];

   // Idle bus level is high, so reset to 1 to avoid a false edge on reset exit.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
         clk_prev_q  <= 1'b1;
      end else begin
         clk_sync_q  <= clk_sync_d;
         data_sync_q <= data_sync_d;
         clk_prev_q  <= clk_prev_d;
      end
   end

   assign clk_sync_o  = clk_sync_q[1];
   assign data_sync_o = data_sync_q[1];
   assign clk_fall_o  = clk_prev_q & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame, ack
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic         app_clk,
   input  logic         app_arst_n,
   ps2_host_tx_if.slave bus
);

   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX);

   localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]       LAST_BIT = 4'(FRAME_LEN - 2);

   state_t               state_q, state_d;
   logic [FRAME_LEN-1:0] shift_q, shift_d;
   logic [3:0]           bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 ack_ok_q, ack_ok_d;
   logic                 err_q, err_d;

   logic clk_sync;
   logic data_sync;
   logic clk_fall;
   logic tmo;

   ps2_sync_edge u_sync (
      .clk_i       (app_clk),
      .rst_ni      (app_arst_n),
      .ps2_clk_i   (bus.ps2_clk_in),
      .ps2_data_i  (bus.ps2_data_in),
      .clk_sync_o  (clk_sync),
      .data_sync_o (data_sync),
      .clk_fall_o  (clk_fall)
   );

   assign tmo = (cnt_q == TO_LAST);

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      cnt_d     = cnt_q;
      ack_ok_d  = ack_ok_q;
      err_d     = err_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.tx_valid) begin
               state_d   = ST_INHIBIT;
               shift_d   = build_frame(bus.tx_data);
               bit_cnt_d = 4'd0;
               cnt_d     = '0;
               ack_ok_d  = 1'b0;
            end
         end
         ST_INHIBIT: begin
            if (cnt_q == INH_LAST) begin
               state_d = ST_REQ;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_REQ: begin
            cnt_d   = '0;
            state_d = ST_SEND;
         end
         ST_SEND, ST_ACK, ST_WAIT_IDLE: begin
            cnt_d = cnt_q + 1'b1;
            // Terminal count beats a coincident falling edge.
            if (tmo) begin
               state_d = ST_DONE;
               err_d   = 1'b1;
            end else if (state_q == ST_SEND) begin
               if (clk_fall) begin
                  shift_d   = {1'b1, shift_q[FRAME_LEN-1:1]};
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == LAST_BIT) begin
                     state_d = ST_ACK;
                  end
               end
            end else if (state_q == ST_ACK) begin
               if (clk_fall) begin
                  ack_ok_d = ~data_sync;
                  state_d  = ST_WAIT_IDLE;
               end
            end else if (clk_sync && data_sync) begin
               state_d = ST_DONE;
               err_d   = ~ack_ok_q;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge app_clk or negedge app_arst_n) begin
      if (!app_arst_n) begin
         state_q   <= ST_IDLE;
         shift_q   <= '1;
         bit_cnt_q <= 4'd0;
         cnt_q     <= '0;
         ack_ok_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         cnt_q     <= cnt_d;
         ack_ok_q  <= ack_ok_d;
         err_q     <= err_d;
      end
   end

   // Line drives decode straight from state so an async reset releases the pads at once.
   assign bus.ps2_clk_oe  = (state_q == ST_INHIBIT) || (state_q == ST_REQ);
   assign bus.ps2_data_oe = (state_q == ST_REQ) || ((state_q == ST_SEND) && !shift_q[0]);
   assign bus.tx_ready    = (state_q == ST_IDLE);
   assign bus.tx_busy     = (state_q != ST_IDLE);
   assign bus.tx_done     = (state_q == ST_DONE);
   assign bus.tx_err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with an open-drain PS/2 device model
module tb_ps2_host_tx;

   localparam int INH = 20;
   localparam int TMO = 1000;

   typedef struct {
      logic [9:0] frame;
      logic       err;
      logic       chk_frame;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic dev_clk_low = 1'b0;
   logic dev_data_low = 1'b0;
   logic [9:0] dev_frame = '0;
   int dev_mode = 0;

   int checks = 0;
   int errors = 0;
   int ncyc = 0;
   int acc_cnt = 0;
   int acc_ncyc = 0;
   int done_cnt = 0;
   int done_ncyc = 0;
   int release_ncyc = 0;
   exp_t exp_q[$];

   ps2_host_tx_if bus ();

   assign bus.ps2_clk_in  = ~(bus.ps2_clk_oe | dev_clk_low);
   assign bus.ps2_data_in = ~(bus.ps2_data_oe | dev_data_low);

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
      .app_clk    (clk),
      .app_arst_n (rst_n),
      .bus        (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Device model: generates the clock for each frame and samples data at the end of each low phase.
   initial begin
      forever begin
         wait (rst_n && !bus.ps2_clk_oe && bus.ps2_data_oe && bus.tx_busy);
         if (dev_mode == 2) begin
            wait (!bus.tx_busy);
         end else begin
            dev_frame = '0;
            for (int i = 0; i < 11; i++) begin
               if (i == 10 && dev_mode == 0) dev_data_low = 1'b1;
               repeat (8) @(posedge clk);
               #1 dev_clk_low = 1'b1;
               repeat (8) @(posedge clk);
               #1;
               if (i < 10) dev_frame[i] = bus.ps2_data_in;
               dev_clk_low = 1'b0;
            end
            repeat (2) @(posedge clk);
            #1 dev_data_low = 1'b0;
            wait (!bus.tx_busy);
         end
      end
   end

   // Monitor: handshake/done bookkeeping, inhibit length, scoreboard compare.
   initial begin
      int   run = 0;
      logic prev_oe = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         ncyc++;
         if (rst_n) begin
            if (bus.tx_valid && bus.tx_ready) begin
               acc_cnt++;
               acc_ncyc = ncyc;
            end
            if (bus.ps2_clk_oe) run++;
            if (prev_oe && !bus.ps2_clk_oe) begin
               chk("clk_low_len", run, INH + 1);
               release_ncyc = ncyc;
               run = 0;
            end
            prev_oe = bus.ps2_clk_oe;
            if (bus.tx_done) begin
               done_cnt++;
               done_ncyc = ncyc;
               if (exp_q.size() == 0) begin
                  chk("done_unexpected", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("tx_err", bus.tx_err, e.err);
                  if (e.chk_frame) chk("frame", dev_frame, e.frame);
                  chk("oe_at_done", {bus.ps2_clk_oe, bus.ps2_data_oe}, 0);
               end
            end
         end else begin
            run = 0;
            prev_oe = 1'b0;
         end
      end
   end

   task automatic wait_accept(input string nm);
      int a0 = acc_cnt;
      int i = 0;
      while (acc_cnt == a0 && i < 3000) begin
         @(posedge clk);
         #1;
         i++;
      end
      chk(nm, acc_cnt != a0, 1);
   endtask

   task automatic send(input logic [7:0] d, input logic [9:0] f, input logic err, input logic cf);
      exp_t e;
      @(posedge clk);
      #1;
      bus.tx_valid = 1'b1;
      bus.tx_data  = d;
      e.frame = f; e.err = err; e.chk_frame = cf;
      exp_q.push_back(e);
      wait_accept("accept");
      bus.tx_valid = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      int d0 = done_cnt;
      int i = 0;
      while (done_cnt == d0 && i < 3000) begin
         @(posedge clk);
         #1;
         i++;
      end
      chk(nm, done_cnt != d0, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=hang expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int a0;
      int d0;
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_clk_oe", bus.ps2_clk_oe, 0);
      chk("rst_data_oe", bus.ps2_data_oe, 0);
      chk("rst_ready", bus.tx_ready, 1);
      chk("rst_busy", bus.tx_busy, 0);
      chk("rst_done", bus.tx_done, 0);
      chk("rst_err", bus.tx_err, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      dev_mode = 0;
      send(8'hF4, 10'h2F4, 1'b0, 1'b1);
      wait_done("done_f4");

      send(8'hED, 10'h3ED, 1'b0, 1'b1);
      bus.tx_valid = 1'b1;
      bus.tx_data  = 8'h00;
      e.frame = 10'h300; e.err = 1'b0; e.chk_frame = 1'b1;
      exp_q.push_back(e);
      wait_accept("accept_b2b");
      bus.tx_valid = 1'b0;
      chk("b2b_accept_cycle", acc_ncyc, done_ncyc + 1);
      wait_done("done_00");

      dev_mode = 1;
      send(8'h5A, 10'h35A, 1'b1, 1'b1);
      wait_done("done_noack");
      repeat (5) @(negedge clk);
      chk("err_hold", bus.tx_err, 1);
      chk("noack_oe", {bus.ps2_clk_oe, bus.ps2_data_oe}, 0);

      dev_mode = 2;
      send(8'h3C, 10'h000, 1'b1, 1'b0);
      wait_done("done_timeout");
      chk("timeout_cycles", done_ncyc - release_ncyc, TMO);

      send(8'h11, 10'h000, 1'b0, 1'b0);
      repeat (INH + 60) @(posedge clk);
      chk("mid_send_busy", bus.tx_busy, 1);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_clk_oe", bus.ps2_clk_oe, 0);
      chk("arst_data_oe", bus.ps2_data_oe, 0);
      chk("arst_busy", bus.tx_busy, 0);
      chk("arst_done", bus.tx_done, 0);
      chk("arst_ready", bus.tx_ready, 1);
      void'(exp_q.pop_back());
      d0 = done_cnt;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (TMO + 200) @(posedge clk);
      chk("no_done_after_rst", done_cnt, d0);

      dev_mode = 0;
      @(posedge clk);
      #1;
      a0 = acc_cnt;
      bus.tx_valid = 1'b1;
      bus.tx_data  = 8'h81;
      e.frame = 10'h381; e.err = 1'b0; e.chk_frame = 1'b1;
      exp_q.push_back(e);
      wait_accept("accept_hold");
      d0 = done_cnt;
      for (int i = 0; i < 3000 && done_cnt == d0; i++) begin
         bus.tx_data = 8'($urandom_range(0, 255));
         @(posedge clk);
         #1;
      end
      bus.tx_valid = 1'b0;
      chk("hold_done_seen", done_cnt != d0, 1);
      repeat (10) @(posedge clk);
      chk("hold_single_accept", acc_cnt, a0 + 1);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
